ioctl_word_loader: RTL and testbench
====================================

Name: ioctl_word_loader

Overview:
- Sits directly downstream of the SPI data-pump block. Consumes its byte-wide ioctl download stream (download flag, write strobe, byte address, byte data) and packs bytes into 16-bit words.
- Buffers the words in a small FIFO and issues them as req/ack write transactions to the SDRAM/ROM arbiter.
- Drives ioctl_wait back upstream so the pump can be throttled. Reports completion and overflow to the core.

Parameters:
- ADDR_W, 25: width of ioctl_addr (byte address).
- FIFO_DEPTH, 4: word FIFO entries; power of two, minimum 4.
- INDEX_VAL, 8'h00: ioctl_index value this loader accepts.
- INDEX_MASK, 8'hFF: bits of ioctl_index compared against INDEX_VAL.

Ports:
- clk_sys, in, 1: system clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- ioctl_download, in, 1: download active flag from the pump.
- ioctl_index, in, 8: menu/file index of the current download.
- ioctl_wr, in, 1: byte write strobe; 2 cycles wide from the pump.
- ioctl_addr, in, ADDR_W: byte address.
- ioctl_dout, in, 8: byte data.
- ioctl_wait, out, 1: backpressure to the pump.
- mem_req, out, 1: write request to the arbiter.
- mem_ack, in, 1: one-cycle acknowledge from the arbiter.
- mem_addr, out, ADDR_W-1: word address (ioctl_addr[ADDR_W-1:1]).
- mem_din, out, 16: write data; low byte = even address.
- mem_be, out, 2: byte enables; [0] = low byte, [1] = high byte.
- busy, out, 1: high from accepted download start until done.
- done, out, 1: one-cycle pulse when all words are written.
- overflow, out, 1: sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFO empty, state IDLE, pack register empty.
- Download qualification: active when ioctl_download=1 and (ioctl_index & INDEX_MASK) == (INDEX_VAL & INDEX_MASK). Index is sampled at the download rising edge and held until done.
- Write capture: a byte is captured only on the rising edge of ioctl_wr (registered edge detect). The 2-cycle strobe yields exactly one capture.
- Packing: a pack register holds {word addr, lo, hi, be}. A captured byte goes to lo if addr[0]=0, hi if addr[0]=1.
- Word push, evaluated in this order:
  - (a) Captured byte's word address differs from the pending word → push the pending word first, then start a new word.
  - (b) hi byte written → push the word (be=2'b11 if lo is valid, else 2'b10).
  - A word pushed with only lo valid has be=2'b01.
- States:
  - IDLE: start a qualified download → LOAD; clear overflow; busy=1.
  - LOAD: capture and pack. On download falling edge → FLUSH.
  - FLUSH: push the pending partial word if any (one cycle) → DRAIN.
  - DRAIN: wait for FIFO empty and no outstanding req → DONE.
  - DONE: done=1 for one cycle; busy=0 → IDLE.
- Memory handshake:
  - mem_req asserted with FIFO head; mem_addr, mem_din and mem_be are stable while mem_req=1.
  - On mem_ack, pop the head. mem_req deasserts the cycle after ack, so there is at least one idle cycle between requests.
  - mem_ack while mem_req=0 is ignored.
- ioctl_wait:
  - In LOAD, high when FIFO count >= FIFO_DEPTH-2. Margin covers the pump's synchroniser latency plus a pending-word push.
  - Forced high in FLUSH and DRAIN. Low in IDLE and DONE.
- Full: a push when the FIFO is full drops the word and sets overflow until the next qualified download start.
- Simultaneous push and pop in one cycle: count unchanged, both take effect.
- Download re-start while in FLUSH/DRAIN: ignored until IDLE; the pump is held off via ioctl_wait.
- Unqualified index: all writes ignored, busy stays 0, no done pulse.
- Address wrap: word address arithmetic is modulo 2^(ADDR_W-1); no special case.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: adds output checksum[15:0], the sum modulo 2^16 of every captured byte (zero-extended). Cleared on qualified download start, stable from the done pulse until the next start, reset to 0.
- Undefined: the port and its logic are absent; no other behaviour changes.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 at addr 0..3, mem_ack 2 cycles after req → words (addr0, 0x2211, be 11), (addr1, 0x4433, be 11); done pulses once; busy low after.
- 3 bytes at addr 0x100..0x102 then download falls → third word pushed with addr 0x81, data lo 0x??, be=01, written before done.
- Non-sequential writes: addr 4 then addr 9 → word 2 be=01, then word 4 be=10.
- mem_ack held low for 50 cycles, 16 bytes pumped → ioctl_wait rises when count reaches 2 (DEPTH=4); no overflow; all 8 words written in order once ack resumes.
- Pump ignores ioctl_wait with 12 back-to-back bytes and ack stalled → overflow=1; stays 1 until the next download start clears it.
- rst_n pulsed low mid-DRAIN with mem_req=1 → mem_req, busy, ioctl_wait all 0 immediately; no done pulse; with LOADER_CHECKSUM_EN, bytes 0xFF×258 → checksum 0x00FE.

Source files
------------

// File: rtl/ioctl_word_loader.sv
`timescale 1ns/1ps
// ioctl_word_loader
//   Packs the byte-wide ioctl download stream from the SPI data pump into
//   16-bit words, buffers them in a small FIFO and writes them to the
//   SDRAM/ROM arbiter through a req/ack handshake.
//
// Ports
//   clk_sys, rst_n       : clock (rising edge), asynchronous active-low reset
//   ioctl_download       : download active flag from the pump
//   ioctl_index          : menu/file index of the current download
//   ioctl_wr             : byte write strobe (2 cycles wide)
//   ioctl_addr/dout      : byte address / byte data
//   ioctl_wait           : backpressure to the pump
//   mem_req/ack          : write request to the arbiter / one-cycle acknowledge
//   mem_addr/din/be      : word address, word data (low byte = even address),
//                          byte enables ([0] = low byte, [1] = high byte)
//   busy                 : from accepted download start until done
//   done                 : one-cycle pulse once every word has been written
//   overflow             : sticky, a word was dropped on a full FIFO
//   checksum             : (LOADER_CHECKSUM_EN only) 16-bit sum of captured bytes
//
// Build option
//   LOADER_CHECKSUM_EN   : adds the checksum output and its accumulator.

module ioctl_word_loader #(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  INDEX_VAL  = 8'h00,
  parameter logic [7:0]  INDEX_MASK = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_be,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LVL  = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [7:0]       INDEX_REF = INDEX_VAL & INDEX_MASK;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic wr_dly_q;

  // Pack register
  logic [ADDR_W-2:0] pk_addr_q, pk_addr_d;
  logic [7:0]        pk_lo_q, pk_lo_d;
  logic [7:0]        pk_hi_q, pk_hi_d;
  logic              pk_lo_v_q, pk_lo_v_d;
  logic              pk_hi_v_q, pk_hi_v_d;

  // Word FIFO
  logic [ADDR_W-2:0] fifo_addr_q [FIFO_DEPTH];
  logic [15:0]       fifo_data_q [FIFO_DEPTH];
  logic [1:0]        fifo_be_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered outputs
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic              wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  // Combinational helpers
  logic              wr_rise;
  logic              qualified;
  logic              capture;
  logic [ADDR_W-2:0] cap_waddr;
  logic              push;
  logic              push_ok;
  logic [ADDR_W-2:0] push_addr;
  logic [15:0]       push_data;
  logic [1:0]        push_be;
  logic              pop;
  logic              fifo_full;

  always_comb begin
    wr_rise   = ioctl_wr & ~wr_dly_q;
    qualified = ioctl_download && ((ioctl_index & INDEX_MASK) == INDEX_REF);
    capture   = (state_q == S_LOAD) && wr_rise;
    cap_waddr = ioctl_addr[ADDR_W-1:1];

    state_d   = state_q;
    pk_addr_d = pk_addr_q;
    pk_lo_d   = pk_lo_q;
    pk_hi_d   = pk_hi_q;
    pk_lo_v_d = pk_lo_v_q;
    pk_hi_v_d = pk_hi_v_q;
    ovf_d     = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    // Any push in a cycle always carries the pack register as it stood at
    // the start of that cycle.
    push      = 1'b0;
    push_addr = pk_addr_q;
    push_data = {pk_hi_q, pk_lo_q};
    push_be   = {pk_hi_v_q, pk_lo_v_q};

    case (state_q)
      S_IDLE: begin
        if (qualified) begin
          state_d   = S_LOAD;
          ovf_d     = 1'b0;
          pk_lo_v_d = 1'b0;
          pk_hi_v_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end

      S_LOAD: begin
        // A word completed by its high byte is pushed the cycle after the
        // capture.  This keeps pushes to one per cycle even when a new
        // high byte also evicts a pending low-only word: captures are at
        // least three cycles apart, so the two pushes never collide.
        if (pk_hi_v_q) begin
          push      = 1'b1;
          pk_lo_v_d = 1'b0;
          pk_hi_v_d = 1'b0;
        end
        if (capture) begin
          if (pk_lo_v_d && (cap_waddr != pk_addr_q)) begin
            push = 1'b1;
          end
          if (!(pk_lo_v_d && (cap_waddr == pk_addr_q))) begin
            pk_addr_d = cap_waddr;
            pk_lo_d   = '0;
            pk_hi_d   = '0;
            pk_lo_v_d = 1'b0;
            pk_hi_v_d = 1'b0;
          end
          if (ioctl_addr[0]) begin
            pk_hi_d   = ioctl_dout;
            pk_hi_v_d = 1'b1;
          end else begin
            pk_lo_d   = ioctl_dout;
            pk_lo_v_d = 1'b1;
          end
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + {8'h00, ioctl_dout};
`endif
        end
        if (!ioctl_download) begin
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (pk_lo_v_q || pk_hi_v_q) begin
          push = 1'b1;
        end
        pk_lo_v_d = 1'b0;
        pk_hi_v_d = 1'b0;
        state_d   = S_DRAIN;
      end

      S_DRAIN: begin
        if ((count_q == '0) && !mem_req_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // FIFO bookkeeping; a push into a full FIFO is still taken if the head
    // leaves in the same cycle.
    pop       = mem_req_q & mem_ack;
    fifo_full = (count_q == FULL_LVL);
    push_ok   = push && (!fifo_full || pop);
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    // Request drops the cycle after ack, so a fresh request always sees a
    // settled read pointer and there is an idle cycle between requests.
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_be_d   = mem_be_q;
    if (mem_req_q) begin
      mem_req_d = ~mem_ack;
    end else begin
      mem_req_d = (count_q != '0);
      if (mem_req_d) begin
        mem_addr_d = fifo_addr_q[rd_ptr_q];
        mem_din_d  = fifo_data_q[rd_ptr_q];
        mem_be_d   = fifo_be_q[rd_ptr_q];
      end
    end

    case (state_d)
      S_LOAD:           wait_d = (count_d >= WAIT_LVL);
      S_FLUSH, S_DRAIN: wait_d = 1'b1;
      default:          wait_d = 1'b0;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_FLUSH) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_dly_q   <= 1'b0;
      pk_addr_q  <= '0;
      pk_lo_q    <= '0;
      pk_hi_q    <= '0;
      pk_lo_v_q  <= 1'b0;
      pk_hi_v_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_be_q   <= '0;
      wait_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_dly_q   <= ioctl_wr;
      pk_addr_q  <= pk_addr_d;
      pk_lo_q    <= pk_lo_d;
      pk_hi_q    <= pk_hi_d;
      pk_lo_v_q  <= pk_lo_v_d;
      pk_hi_v_q  <= pk_hi_v_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_be_q   <= mem_be_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Storage array; contents are qualified by the pointers and count.
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      fifo_addr_q[wr_ptr_q] <= push_addr;
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_be_q[wr_ptr_q]   <= push_be;
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_be     = mem_be_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_ioctl_word_loader.sv
`timescale 1ns/1ps
// Bench for ioctl_word_loader (default parameters: ADDR_W=25, FIFO_DEPTH=4,
// INDEX_VAL=0, INDEX_MASK=FF).  A pump model drives byte writes, an arbiter
// model acknowledges requests and records every written word.
module tb_ioctl_word_loader;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  ioctl_word_loader #(
    .ADDR_W     (25),
    .FIFO_DEPTH (4),
    .INDEX_VAL  (8'h00),
    .INDEX_MASK (8'hFF)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_be         (mem_be),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          grp;
    logic [24:0] addr;
    logic [7:0]  dat;
  } byte_vec_t;

  typedef struct {
    int          grp;
    logic [23:0] waddr;
    logic [15:0] din;
    logic [1:0]  be;
  } word_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    stall_until = 0;
  int    done_cnt = 0;
  logic  stray_ack = 1'b0;
  word_t got_q[$];
  word_t exp_q[$];

  always @(posedge clk_sys) cyc++;
  always @(posedge clk_sys) begin
    #1;
    if (done) done_cnt++;
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Arbiter: acknowledges 2 cycles after a request appears (unless stalled),
  // checks the request fields stay put and that req drops right after ack.
  initial begin
    int          age;
    bit          held;
    bit          gap_chk;
    logic [41:0] snap;
    word_t       w;
    age = 0; held = 0; gap_chk = 0; snap = '0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      mem_ack = stray_ack;
      if (!rst_n) begin
        age = 0; held = 0; gap_chk = 0;
      end else if (gap_chk) begin
        check("req_gap_after_ack", mem_req, 1'b0);
        gap_chk = 0;
      end else if (mem_req) begin
        if (!held) begin
          snap = {mem_addr, mem_din, mem_be};
          held = 1;
        end
        if (cyc >= stall_until) age++;
        if (age >= 2) begin
          check("req_fields_stable", {mem_addr, mem_din, mem_be}, snap);
          w.grp = 0; w.waddr = mem_addr; w.din = mem_din; w.be = mem_be;
          got_q.push_back(w);
          mem_ack = 1'b1;
          age = 0; held = 0; gap_chk = 1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_download(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input bit honor);
    int t;
    t = 0;
    if (honor) begin
      while (ioctl_wait && t < 2000) begin
        @(negedge clk_sys);
        t++;
      end
      if (t >= 2000) check("pump_wait_bound", 1'b1, 1'b0);
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    repeat (2) @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic finish_download(input string nm, input int limit);
    int start_cnt;
    int t;
    start_cnt = done_cnt;
    t = 0;
    ioctl_download = 1'b0;
    while (done_cnt == start_cnt && t < limit) begin
      @(negedge clk_sys);
      t++;
    end
    check({nm, "_done_seen"}, (done_cnt != start_cnt), 1'b1);
    repeat (5) @(negedge clk_sys);
    check({nm, "_done_once"}, done_cnt - start_cnt, 1);
    check({nm, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic compare_words(input string nm);
    logic [15:0] m;
    check({nm, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      m = {{8{exp_q[i].be[1]}}, {8{exp_q[i].be[0]}}};
      check($sformatf("%s_word%0d", nm, i),
            {got_q[i].waddr, got_q[i].din & m, got_q[i].be},
            {exp_q[i].waddr, exp_q[i].din & m, exp_q[i].be});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  byte_vec_t bv[14];
  word_t     wv[9];

  initial begin
    int    prev_done;
    word_t w;

    bv[0]  = '{0, 25'h0000000, 8'h11};
    bv[1]  = '{0, 25'h0000001, 8'h22};
    bv[2]  = '{0, 25'h0000002, 8'h33};
    bv[3]  = '{0, 25'h0000003, 8'h44};
    bv[4]  = '{1, 25'h0000100, 8'hAA};
    bv[5]  = '{1, 25'h0000101, 8'hBB};
    bv[6]  = '{1, 25'h0000102, 8'hCC};
    bv[7]  = '{2, 25'h0000004, 8'h55};
    bv[8]  = '{2, 25'h0000009, 8'h66};
    bv[9]  = '{2, 25'h000000A, 8'h99};
    bv[10] = '{2, 25'h000000B, 8'h9A};
    bv[11] = '{3, 25'h1FFFFFE, 8'h12};
    bv[12] = '{3, 25'h1FFFFFF, 8'h34};
    bv[13] = '{3, 25'h0000000, 8'h56};

    wv[0] = '{0, 24'h000000, 16'h2211, 2'b11};
    wv[1] = '{0, 24'h000001, 16'h4433, 2'b11};
    wv[2] = '{1, 24'h000080, 16'hBBAA, 2'b11};
    wv[3] = '{1, 24'h000081, 16'h00CC, 2'b01};
    wv[4] = '{2, 24'h000002, 16'h0055, 2'b01};
    wv[5] = '{2, 24'h000004, 16'h6600, 2'b10};
    wv[6] = '{2, 24'h000005, 16'h9A99, 2'b11};
    wv[7] = '{3, 24'hFFFFFF, 16'h3412, 2'b11};
    wv[8] = '{3, 24'h000000, 16'h0056, 2'b01};

    rst_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);

    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_mem_fields", {mem_addr, mem_din, mem_be}, 42'h0);
`ifdef LOADER_CHECKSUM_EN
    check("rst_checksum", checksum, 16'h0000);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Stray ack while idle must not disturb anything.
    stray_ack = 1'b1;
    @(negedge clk_sys);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("stray_ack_req", mem_req, 1'b0);

    // Table-driven downloads, ack 2 cycles after req.
    for (int g = 0; g < 4; g++) begin
      start_download(8'h00);
      check($sformatf("grp%0d_busy", g), busy, 1'b1);
      for (int i = 0; i < 14; i++)
        if (bv[i].grp == g) write_byte(bv[i].addr, bv[i].dat, 1'b1);
      finish_download($sformatf("grp%0d", g), 500);
      for (int i = 0; i < 9; i++)
        if (wv[i].grp == g) exp_q.push_back(wv[i]);
      compare_words($sformatf("grp%0d", g));
    end

    // Backpressure: ack stalled 50 cycles, pump honours ioctl_wait.
    stall_until = cyc + 50;
    start_download(8'h00);
    for (int i = 0; i < 16; i++) begin
      write_byte(25'h20 + 25'(i), 8'hA0 + 8'(i), 1'b1);
      if (i == 1) begin
        check("bp_wait_low_at_count1", ioctl_wait, 1'b0);
        check("bp_req_pending", mem_req, 1'b1);
      end
      if (i == 3) check("bp_wait_high_at_count2", ioctl_wait, 1'b1);
    end
    finish_download("bp", 2000);
    check("bp_no_overflow", overflow, 1'b0);
    for (int k = 0; k < 8; k++) begin
      w.grp = 0; w.waddr = 24'h10 + 24'(k);
      w.din = {8'hA0 + 8'(2*k+1), 8'hA0 + 8'(2*k)}; w.be = 2'b11;
      exp_q.push_back(w);
    end
    compare_words("bp");

    // Overflow: pump ignores wait, ack stalled.
    stall_until = cyc + 100000;
    start_download(8'h00);
    for (int i = 0; i < 12; i++)
      write_byte(25'h40 + 25'(i), 8'h40 + 8'(i), 1'b0);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("ovf_set", overflow, 1'b1);
    check("ovf_wait_in_drain", ioctl_wait, 1'b1);
    stall_until = 0;
    finish_download("ovf", 500);
    check("ovf_sticky_after_done", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      w.grp = 0; w.waddr = 24'h20 + 24'(k);
      w.din = {8'h40 + 8'(2*k+1), 8'h40 + 8'(2*k)}; w.be = 2'b11;
      exp_q.push_back(w);
    end
    compare_words("ovf");
    start_download(8'h00);
    check("ovf_cleared_on_start", overflow, 1'b0);
    finish_download("empty_dl", 200);
    check("empty_dl_words", got_q.size(), 0);

    // Unqualified index.
    prev_done = done_cnt;
    start_download(8'h01);
    check("unq_busy", busy, 1'b0);
    write_byte(25'h0, 8'h77, 1'b1);
    write_byte(25'h1, 8'h78, 1'b1);
    ioctl_download = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("unq_no_done", done_cnt - prev_done, 0);
    check("unq_no_words", got_q.size(), 0);
    check("unq_busy_end", busy, 1'b0);

    // Reset in the middle of DRAIN with a request outstanding.
    stall_until = cyc + 100000;
    start_download(8'h00);
    for (int i = 0; i < 4; i++) write_byte(25'(i), 8'(i), 1'b1);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rstdrain_pre_req", mem_req, 1'b1);
    check("rstdrain_pre_busy", busy, 1'b1);
    prev_done = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rstdrain_req", mem_req, 1'b0);
    check("rstdrain_busy", busy, 1'b0);
    check("rstdrain_wait", ioctl_wait, 1'b0);
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    stall_until = 0;
    repeat (20) @(negedge clk_sys);
    check("rstdrain_no_done", done_cnt - prev_done, 0);
    check("rstdrain_req_idle", mem_req, 1'b0);
    got_q.delete();
    exp_q.delete();

`ifdef LOADER_CHECKSUM_EN
    start_download(8'h00);
    for (int i = 0; i < 258; i++) write_byte(25'(i), 8'hFF, 1'b1);
    finish_download("csum", 3000);
    check("csum_value", checksum, 16'h00FE);
    repeat (4) @(negedge clk_sys);
    check("csum_stable", checksum, 16'h00FE);
    check("csum_nwords", got_q.size(), 129);
    got_q.delete();
    start_download(8'h00);
    check("csum_cleared_on_start", checksum, 16'h0000);
    finish_download("csum_empty", 200);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
